// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types and constants for the store write buffer
package store_buffer_pkg;

    localparam int SB_DEPTH_DEF  = 4;
    localparam int SB_MEM_AW_DEF = 14;

    localparam logic [31:0] BWEB_NONE = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [SB_MEM_AW_DEF-1:0] addr;
        logic [31:0]              data;
        logic [31:0]              bweb;
    } sb_entry_t;

endpackage

// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - folds a new masked store into an older entry for the same word
module store_merge_unit (
    input  logic [31:0] old_data,
    input  logic [31:0] old_bweb,
    input  logic [31:0] new_data,
    input  logic [31:0] new_bweb,
    output logic [31:0] merged_data,
    output logic [31:0] merged_bweb
);

    // Bits the new store enables (bweb low) take the new data; the rest keep the old.
    assign merged_data = (old_data & new_bweb) | (new_data & ~new_bweb);
    assign merged_bweb = old_bweb & new_bweb;

endmodule

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - coalescing store FIFO between the MEM stage and the data SRAM
module store_write_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH_DEF,
    parameter int MEM_AW = SB_MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_wdata,
    input  logic [31:0]       st_bweb,
    output logic              sb_stall,
    input  logic              ld_valid,
    input  logic [31:0]       ld_addr,
    output logic              ld_hazard,
    output logic              sb_empty,
    output logic              mem_ceb,
    output logic              mem_web,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       mem_bweb,
    input  logic              mem_ready
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [31:0]       data;
        logic [31:0]       bweb;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     youngest;
    logic [PW:0]       count;

    logic [MEM_AW-1:0] st_word;
    logic [MEM_AW-1:0] ld_word;
    logic              merge_hit;
    logic              do_push;
    logic              do_pop;
    logic              full;
    logic [31:0]       merged_data;
    logic [31:0]       merged_bweb;
    logic [DEPTH-1:0]  ld_match;
    logic              unused_addr_bits;

    assign st_word          = st_addr[MEM_AW+1:2];
    assign ld_word          = ld_addr[MEM_AW+1:2];
    assign unused_addr_bits = ^{st_addr[31:MEM_AW+2], st_addr[1:0], ld_addr[31:MEM_AW+2], ld_addr[1:0]};

    assign youngest = tail - PW'(1);
    assign full     = (count == (PW+1)'(DEPTH));
    assign sb_empty = (count == '0);

    // Requiring two entries keeps the head, which may be on the SRAM port, out of reach.
    assign merge_hit = st_valid && (count >= (PW+1)'(2)) && (entries[youngest].addr == st_word);
    assign do_push   = st_valid && !merge_hit && !full;
    assign do_pop    = !sb_empty && mem_ready;
    assign sb_stall  = st_valid && !merge_hit && full;

    store_merge_unit u_merge (
        .old_data    (entries[youngest].data),
        .old_bweb    (entries[youngest].bweb),
        .new_data    (st_wdata),
        .new_bweb    (st_bweb),
        .merged_data (merged_data),
        .merged_bweb (merged_bweb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (merge_hit) begin
                entries[youngest].data <= merged_data;
                entries[youngest].bweb <= merged_bweb;
            end
            if (do_push) begin
                entries[tail] <= '{addr: st_word, data: st_wdata, bweb: st_bweb};
                tail          <= tail + PW'(1);
            end
            if (do_pop) begin
                head <= head + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // An entry is live when its distance from head is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ld_match
        logic [PW-1:0] rel;
        assign rel         = PW'(g) - head;
        assign ld_match[g] = ({1'b0, rel} < count) && (entries[g].addr == ld_word);
    end

    assign ld_hazard = ld_valid && (|ld_match);

    assign mem_ceb   = sb_empty;
    assign mem_web   = sb_empty;
    assign mem_addr  = sb_empty ? '0        : entries[head].addr;
    assign mem_wdata = sb_empty ? '0        : entries[head].data;
    assign mem_bweb  = sb_empty ? BWEB_NONE : entries[head].bweb;

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Sits directly downstream of the store memory control unit, between the MEM stage and the data SRAM port.
- Accepts formatted stores: word-aligned data plus a 32-bit active-low bit-write-enable mask.
- Queues them in a small FIFO, coalesces back-to-back stores to the same word, and drains them to the SRAM with a ready handshake.
- Stalls the pipeline when full, flags loads that hit a pending store, and reports empty for fences.

Parameters:
- DEPTH, 4, number of buffer entries (power of two, >=2).
- MEM_AW, 14, SRAM word-address width; the word address is st_addr[MEM_AW+1:2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- st_valid  in  1  store request from the store control unit (its is_store).
- st_addr  in  32  byte address of the store; bits [1:0] are ignored.
- st_wdata  in  32  lane-aligned store data.
- st_bweb  in  32  bit write enable, active-low: 0 = write this bit.
- sb_stall  out  1  store not accepted this cycle; the pipeline must hold.
- ld_valid  in  1  load in the MEM stage.
- ld_addr  in  32  load byte address.
- ld_hazard  out  1  the load's word matches a pending entry; the load must stall.
- sb_empty  out  1  count==0; used by fence/CSR logic.
- mem_ceb  out  1  SRAM chip enable, active-low.
- mem_web  out  1  SRAM write enable, active-low.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_bweb  out  32  SRAM bit write enable, active-low.
- mem_ready  in  1  SRAM accepts the presented write at this edge.

Behaviour:
- State:
  - Entry array of {addr[MEM_AW-1:0], data, bweb}.
  - Head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Count of log2(DEPTH)+1 bits.
- Reset (rst_n==0 at an edge):
  - count=0 and head=tail=0; entry contents are don't-care.
  - After that edge: mem_ceb=1, mem_web=1, mem_bweb=32'hFFFFFFFF, mem_addr=0, mem_wdata=0, sb_empty=1, sb_stall=0 when st_valid=0, ld_hazard=0.
  - Reset mid-drain drops all entries, including the one being presented.
- Drain:
  - While count>0, the head entry is presented combinationally from registers: mem_ceb=0, mem_web=0, mem_addr/mem_wdata/mem_bweb = head fields.
  - The presented fields hold stable until mem_ready=1 at an edge. That edge pops the head.
  - When count==0 all mem_* outputs take their idle values.
  - Write latency: a store accepted at edge N is presented from cycle N+1.
- Merge:
  - Condition: st_valid && count>=2 && st word address == youngest entry (tail-1) addr.
  - The head is never merged, since it may be in flight.
  - Merge rule, with ne = ~st_bweb: data = (old & ~ne) | (st_wdata & ne); bweb = old_bweb & st_bweb.
  - Count and tail are unchanged. A merge is accepted even when the buffer is full.
- Push:
  - If st_valid, no merge, and count<DEPTH, write the tail entry, tail+1.
- Stall:
  - sb_stall = st_valid && !merge && count==DEPTH.
  - Conservative rule: a pop in the same cycle does not free the slot.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Simultaneous merge and pop: legal, since the merge target is never the head (count>=2).
- ld_hazard = ld_valid && (any valid entry addr == ld_addr[MEM_AW+1:2]). Purely combinational; an entry popping in the current cycle still counts.
- sb_empty = (count==0), combinational from the count register.
- A store with st_bweb==32'hFFFFFFFF (no bits enabled) is still queued and written.

Decomposition:
- Package store_buffer_pkg holds:
  - typedef sb_entry_t {logic [MEM_AW-1:0] addr; logic [31:0] data; logic [31:0] bweb;}
  - constant BWEB_NONE = 32'hFFFFFFFF
  - constant SB_DEPTH_DEF = 4
- One combinational sub-module, store_merge_unit: inputs old data/bweb and new data/bweb; outputs merged data/bweb.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with st_valid=1 -> mem_ceb=1, mem_bweb=FFFFFFFF, sb_empty=1; after release, nothing from the reset cycles is queued.
2. Single write, mem_ready=1:
   - Stimulus: SW at st_addr=0x100, st_wdata=0xDEADBEEF, st_bweb=0.
   - Response: next cycle mem_ceb=0, mem_addr=0x40, mem_wdata=0xDEADBEEF, mem_bweb=0; the following cycle sb_empty=1.
3. Full and stall, mem_ready=0:
   - Stimulus: 4 stores to 0x0, 0x4, 0x8, 0xC, then a 5th to 0x10.
   - Response: the 5th sees sb_stall=1 and is held. Once mem_ready=1, mem_addr sequence is 0,1,2,3, then 4.
4. Merge, mem_ready=0:
   - Stimulus: store 0x0; store 0x20 with data 0x11223344, bweb 0; SB to 0x21 with data 0x0000AA00, bweb 32'hFFFF00FF.
   - Response: count stays 2; entry 1 = 0x1122AA44 with bweb 0.
5. Load hazard: pending store at 0x200 -> ld_addr=0x203 gives ld_hazard=1; ld_addr=0x204 gives 0; ld_valid=0 gives 0.
6. Reset mid-drain: 3 entries pending with mem_ready=0, then rst_n=0 -> next cycle mem_ceb=1, sb_empty=1, and none of those entries is ever written.
